// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
//   Groups the per-master request side and the shared SoC memory bus side
//   of the round-robin bus arbiter.
//   Parameter: NUM_M - number of masters (2..4).
//   Master side : req_i, lock_i, wstrb_i, addr_i, wvalue_i (packed, master i
//                 at slice i) -> gnt_o, rvalid_o, rdata_o.
//   Bus side    : bus_enable_o, bus_wstrb_o, bus_addr_o, bus_wvalue_o,
//                 bus_addr_prev_o -> bus_rvalue_i.
//   modport slave  : the arbiter's view.
//   modport master : the view of the surrounding SoC (masters + region mux).
interface bus_arbiter_if #(
    parameter int unsigned NUM_M = 2
);
    logic [NUM_M-1:0]    req_i;
    logic [NUM_M-1:0]    lock_i;
    logic [4*NUM_M-1:0]  wstrb_i;
    logic [32*NUM_M-1:0] addr_i;
    logic [32*NUM_M-1:0] wvalue_i;
    logic [NUM_M-1:0]    gnt_o;
    logic [NUM_M-1:0]    rvalid_o;
    logic [31:0]         rdata_o;
    logic                bus_enable_o;
    logic [3:0]          bus_wstrb_o;
    logic [31:0]         bus_addr_o;
    logic [31:0]         bus_wvalue_o;
    logic [31:0]         bus_addr_prev_o;
    logic [31:0]         bus_rvalue_i;

    modport slave (
        input  req_i, lock_i, wstrb_i, addr_i, wvalue_i, bus_rvalue_i,
        output gnt_o, rvalid_o, rdata_o, bus_enable_o, bus_wstrb_o,
               bus_addr_o, bus_wvalue_o, bus_addr_prev_o
    );

    modport master (
        output req_i, lock_i, wstrb_i, addr_i, wvalue_i, bus_rvalue_i,
        input  gnt_o, rvalid_o, rdata_o, bus_enable_o, bus_wstrb_o,
               bus_addr_o, bus_wvalue_o, bus_addr_prev_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter sharing the single SoC memory bus between NUM_M
//   masters. Grants are combinational in the request cycle; read data is
//   returned one cycle after a read grant and steered with rvalid_o.
//   Owns the registered previous bus address used for read-data decode.
//
//   Parameters: NUM_M (2..4), MAX_BURST (1..255, locked builds only).
//   Ports     : clk_i  - system clock
//               rst_i  - synchronous active-high reset
//               bus    - bus_arbiter_if.slave (master requests + shared bus)
//
//   Build option: define BUS_ARB_LOCK_EN to enable locked bursts (LOCKED
//   state, owner, burst counter capped at MAX_BURST). Without it lock_i is
//   ignored and arbitration is pure per-access round-robin.
module bus_arbiter #(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    bus_arbiter_if.slave bus
);

    typedef logic [1:0] idx_t;

    function automatic idx_t next_idx(input idx_t m);
        return (m == idx_t'(NUM_M - 1)) ? '0 : m + 2'd1;
    endfunction

    idx_t             ptr_q, ptr_d;
    logic             rr_valid;
    idx_t             rr_idx;
    logic             grant_valid;
    idx_t             grant_idx;
    logic [NUM_M-1:0] gnt;
    logic [NUM_M-1:0] rvalid_q, rd_d;
    logic [31:0]      addr_prev_q;
    logic             b_en;
    logic [3:0]       b_wstrb;
    logic [31:0]      b_addr;
    logic [31:0]      b_wdata;

    // Round-robin search: first requester at or above ptr, else wrap to the
    // lowest requester.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!rr_valid && bus.req_i[i] && (idx_t'(i) >= ptr_q)) begin
                rr_valid = 1'b1;
                rr_idx   = idx_t'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (!rr_valid && bus.req_i[i]) begin
                rr_valid = 1'b1;
                rr_idx   = idx_t'(i);
            end
        end
    end

`ifdef BUS_ARB_LOCK_EN
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

    state_t     state_q, state_d;
    idx_t       owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       own_req, own_lock, win_lock;

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        win_lock = 1'b0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (owner_q == idx_t'(i)) begin
                own_req  = bus.req_i[i];
                own_lock = bus.lock_i[i];
            end
            if (rr_idx == idx_t'(i)) begin
                win_lock = bus.lock_i[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_valid = 1'b0;
        grant_idx   = owner_q;
        cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (!rst_i) begin
            if (state_q == LOCKED && own_lock) begin
                if (own_req) begin
                    grant_valid = 1'b1;
                    grant_idx   = owner_q;
                    cnt_d       = cnt_inc;
                    if (cnt_inc >= BURST_CAP) begin
                        state_d = IDLE;
                        ptr_d   = next_idx(owner_q);
                    end
                end
            end else begin
                // Free arbitration; also covers the owner dropping its lock.
                state_d = IDLE;
                if (rr_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_idx;
                    ptr_d       = next_idx(rr_idx);
                    // With a cap of one the first grant already exhausts the burst.
                    if (win_lock && (BURST_CAP > 8'd1)) begin
                        state_d = LOCKED;
                        owner_d = rr_idx;
                        cnt_d   = 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb begin
        ptr_d       = ptr_q;
        grant_valid = 1'b0;
        grant_idx   = rr_idx;
        if (!rst_i && rr_valid) begin
            grant_valid = 1'b1;
            ptr_d       = next_idx(rr_idx);
        end
    end
`endif

    // Grant vector and shared-bus mux; everything reads as zero without a grant.
    always_comb begin
        gnt     = '0;
        b_wstrb = '0;
        b_addr  = '0;
        b_wdata = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant_valid && (grant_idx == idx_t'(i))) begin
                gnt[i]  = 1'b1;
                b_wstrb = bus.wstrb_i[4*i +: 4];
                b_addr  = bus.addr_i[32*i +: 32];
                b_wdata = bus.wvalue_i[32*i +: 32];
            end
        end
        b_en = grant_valid;
        rd_d = (b_wstrb == 4'h0) ? gnt : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            rvalid_q    <= '0;
            addr_prev_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rvalid_q    <= rd_d;
            addr_prev_q <= b_addr;
        end
    end

    assign bus.gnt_o           = gnt;
    // Reset arriving the cycle after a read grant cancels that read return.
    assign bus.rvalid_o        = rvalid_q & {NUM_M{~rst_i}};
    assign bus.rdata_o         = bus.bus_rvalue_i;
    assign bus.bus_enable_o    = b_en;
    assign bus.bus_wstrb_o     = b_wstrb;
    assign bus.bus_addr_o      = b_addr;
    assign bus.bus_wvalue_o    = b_wdata;
    assign bus.bus_addr_prev_o = addr_prev_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter with two masters and MAX_BURST=4.
//   Each test task drives per-cycle stimulus with the expected grant; the
//   expected read return and previous address are queued at grant time and
//   checked the following cycle. Lock scenarios are selected by
//   BUS_ARB_LOCK_EN to match the RTL build.
module tb_bus_arbiter;
    localparam int unsigned NM    = 2;
    localparam int unsigned MB    = 4;
    localparam logic [31:0] RMASK = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_M(NM)) bif ();

    bus_arbiter #(.NUM_M(NM), .MAX_BURST(MB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    // Region-mux model: read data is a fixed function of the previous address.
    assign bif.bus_rvalue_i = bif.bus_addr_prev_o ^ RMASK;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] data;
        logic [31:0] prev;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_wstrb[2];

    task automatic drive(input logic [1:0] req, input logic [1:0] lock);
        bif.req_i    = req;
        bif.lock_i   = lock;
        bif.addr_i   = {m_addr[1], m_addr[0]};
        bif.wvalue_i = {m_wdata[1], m_wdata[0]};
        bif.wstrb_i  = {m_wstrb[1], m_wstrb[0]};
    endtask

    task automatic sb_restart();
        exp_t z;
        z.rv = 2'b00; z.data = '0; z.prev = '0;
        sb.delete();
        sb.push_back(z);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        sb_restart();
    endtask

    // One bus cycle: called at a negedge, drives inputs, checks, ends at next negedge.
    task automatic step(input string tag, input logic [1:0] req,
                        input logic [1:0] lock, input logic [1:0] exp_gnt);
        exp_t        e, n;
        logic [31:0] ea, ew;
        logic [3:0]  es;
        drive(req, lock);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bif.rvalid_o !== e.rv) begin
                errors++;
                $display("FAIL %s rvalid_o got=%b exp=%b", tag, bif.rvalid_o, e.rv);
            end
            if (e.rv != 2'b00) begin
                checks++;
                if (bif.rdata_o !== e.data) begin
                    errors++;
                    $display("FAIL %s rdata_o got=%h exp=%h", tag, bif.rdata_o, e.data);
                end
            end
            checks++;
            if (bif.bus_addr_prev_o !== e.prev) begin
                errors++;
                $display("FAIL %s bus_addr_prev_o got=%h exp=%h", tag, bif.bus_addr_prev_o, e.prev);
            end
        end
        case (exp_gnt)
            2'b01:   begin ea = m_addr[0]; ew = m_wdata[0]; es = m_wstrb[0]; end
            2'b10:   begin ea = m_addr[1]; ew = m_wdata[1]; es = m_wstrb[1]; end
            default: begin ea = '0;        ew = '0;         es = '0;         end
        endcase
        checks++;
        if (bif.gnt_o !== exp_gnt) begin
            errors++;
            $display("FAIL %s gnt_o got=%b exp=%b", tag, bif.gnt_o, exp_gnt);
        end
        checks++;
        if (bif.bus_enable_o !== (exp_gnt != 2'b00)) begin
            errors++;
            $display("FAIL %s bus_enable_o got=%b exp=%b", tag, bif.bus_enable_o, (exp_gnt != 2'b00));
        end
        checks++;
        if (bif.bus_addr_o !== ea) begin
            errors++;
            $display("FAIL %s bus_addr_o got=%h exp=%h", tag, bif.bus_addr_o, ea);
        end
        checks++;
        if (bif.bus_wstrb_o !== es || bif.bus_wvalue_o !== ew) begin
            errors++;
            $display("FAIL %s bus_wstrb/wvalue got=%h/%h exp=%h/%h", tag,
                     bif.bus_wstrb_o, bif.bus_wvalue_o, es, ew);
        end
        n.rv   = (exp_gnt != 2'b00 && es == 4'h0) ? exp_gnt : 2'b00;
        n.data = ea ^ RMASK;
        n.prev = ea;
        sb.push_back(n);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_addr[0] = 32'h1111_0000; m_addr[1] = 32'h2222_0000;
        m_wstrb[0] = 4'h0; m_wstrb[1] = 4'h0;
        drive(2'b11, 2'b11);
        #1;
        checks++;
        if (bif.gnt_o !== 2'b00 || bif.bus_enable_o !== 1'b0 || bif.bus_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_comb gnt/en/addr got=%b/%b/%h exp=00/0/0",
                     bif.gnt_o, bif.bus_enable_o, bif.bus_addr_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bif.rvalid_o !== 2'b00 || bif.bus_addr_prev_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs rvalid/prev got=%b/%h exp=00/0", bif.rvalid_o, bif.bus_addr_prev_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 2'b00);
        sb_restart();
    endtask

    task automatic test_single_read();
        do_reset();
        m_addr[0] = 32'h2000_0010; m_wstrb[0] = 4'h0; m_wdata[0] = 32'h0;
        step("single_rd", 2'b01, 2'b00, 2'b01);
        step("single_ret", 2'b00, 2'b00, 2'b00);
        step("single_idle", 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_round_robin_writes();
        logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        m_wstrb[0] = 4'hF; m_wstrb[1] = 4'h3;
        for (int i = 0; i < 4; i++) begin
            m_addr[0]  = 32'h4000_0000 + 32'(i) * 4;
            m_addr[1]  = 32'h5000_0000 + 32'(i) * 4;
            m_wdata[0] = 32'hDEAD_0000 + 32'(i);
            m_wdata[1] = 32'hBEEF_0000 + 32'(i);
            step($sformatf("rr_wr%0d", i), 2'b11, 2'b00, exp_g[i]);
        end
        step("rr_wr_idle", 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        m_wstrb[0] = 4'h0; m_wstrb[1] = 4'h0;
        m_wdata[0] = 32'h0; m_wdata[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            m_addr[0] = 32'h1000_0000 + 32'(i) * 4;
            m_addr[1] = 32'h3000_0100 + 32'(i) * 8;
            step($sformatf("b2b_rd%0d", i), 2'b11, 2'b00, exp_g[i]);
        end
        step("b2b_ret", 2'b00, 2'b00, 2'b00);
    endtask

`ifdef BUS_ARB_LOCK_EN
    task automatic test_burst_cap();
        logic [1:0] exp_g[6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        do_reset();
        m_addr[0] = 32'h2000_0040; m_wstrb[0] = 4'h0; m_wdata[0] = 32'h0;
        m_addr[1] = 32'h6000_0000; m_wstrb[1] = 4'hF; m_wdata[1] = 32'hCAFE_0001;
        step("cap_pre", 2'b01, 2'b00, 2'b01);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("cap%0d", i), 2'b11, 2'b10, exp_g[i]);
        end
        step("cap_idle", 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_lock_idle();
        do_reset();
        m_addr[0] = 32'h7000_0000; m_wstrb[0] = 4'hF; m_wdata[0] = 32'h1234_5678;
        m_addr[1] = 32'h7000_0100; m_wstrb[1] = 4'h0; m_wdata[1] = 32'h0;
        step("lk_grab", 2'b01, 2'b01, 2'b01);
        step("lk_hold0", 2'b10, 2'b01, 2'b00);
        step("lk_hold1", 2'b10, 2'b01, 2'b00);
        step("lk_drop", 2'b10, 2'b00, 2'b10);
        step("lk_ret", 2'b00, 2'b00, 2'b00);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_addr[0] = 32'h2000_0080; m_wstrb[0] = 4'h0; m_wdata[0] = 32'h0;
        m_addr[1] = 32'h6000_0080; m_wstrb[1] = 4'hF; m_wdata[1] = 32'h0BAD_F00D;
        step("rmb_lock", 2'b01, 2'b01, 2'b01);
        step("rmb_rd", 2'b01, 2'b01, 2'b01);
        rst = 1'b1;
        drive(2'b01, 2'b01);
        #1;
        checks++;
        if (bif.rvalid_o !== 2'b00 || bif.gnt_o !== 2'b00 || bif.bus_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL rmb_rst rvalid/gnt/en got=%b/%b/%b exp=00/00/0",
                     bif.rvalid_o, bif.gnt_o, bif.bus_enable_o);
        end
        @(negedge clk);
        rst = 1'b0;
        sb_restart();
        m_wstrb[0] = 4'hF; m_wdata[0] = 32'h0000_0055;
        step("rmb_after", 2'b11, 2'b00, 2'b01);
        step("rmb_idle", 2'b00, 2'b00, 2'b00);
    endtask
`else
    task automatic test_lock_ignored();
        logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        m_addr[0] = 32'h4400_0000; m_wstrb[0] = 4'h1; m_wdata[0] = 32'h0000_00AA;
        m_addr[1] = 32'h4400_0100; m_wstrb[1] = 4'h8; m_wdata[1] = 32'hBB00_0000;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("nolk%0d", i), 2'b11, 2'b10, exp_g[i]);
        end
        step("nolk_idle", 2'b00, 2'b00, 2'b00);
    endtask
`endif

    initial begin
        m_addr[0] = '0; m_addr[1] = '0;
        m_wdata[0] = '0; m_wdata[1] = '0;
        m_wstrb[0] = '0; m_wstrb[1] = '0;
        drive(2'b00, 2'b00);
        @(negedge clk);
        test_reset();
        test_single_read();
        test_round_robin_writes();
        test_back_to_back();
`ifdef BUS_ARB_LOCK_EN
        test_burst_cap();
        test_lock_idle();
        test_reset_mid_burst();
`else
        test_lock_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single SoC memory bus (enable/wstrb/addr/wvalue out, rvalue back one cycle later) between up to four bus masters, e.g. the CPU plus DMA or video-fetch engines. It sits between the masters and the address-region decode in the SoC top. It owns the registered previous-address used for read-data steering. It supports optional locked bursts with a bounded length, so no master can starve the others.

## Interface
- NUM_M, 2, number of masters (2..4); master 0 has the lowest index and is the reset round-robin head
- MAX_BURST, 8, max consecutive locked grants to one master (1..255)
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- req_i  in  NUM_M  per-master access request; held until granted
- lock_i  in  NUM_M  per-master lock request, sampled together with req_i
- wstrb_i  in  4*NUM_M  per-master byte strobes; all zero means a read
- addr_i  in  32*NUM_M  per-master byte address
- wvalue_i  in  32*NUM_M  per-master write data
- gnt_o  out  NUM_M  one-hot grant, combinational in the request cycle
- rvalid_o  out  NUM_M  one-hot; read data for that master is on rdata_o this cycle
- rdata_o  out  32  pass-through of bus_rvalue_i
- bus_enable_o  out  1  shared bus enable
- bus_wstrb_o  out  4  shared bus strobes
- bus_addr_o  out  32  shared bus address
- bus_wvalue_o  out  32  shared bus write data
- bus_addr_prev_o  out  32  bus_addr_o registered, used for region-decode of read data
- bus_rvalue_i  in  32  read data from the region mux, valid the cycle after a read

## Operation
- States: IDLE (free arbitration) and LOCKED (owner register valid).
- IDLE:
  - Grant the first requester found scanning from ptr upward, modulo NUM_M.
  - After a grant to m, set ptr to (m+1) mod NUM_M.
  - If the granted master also has lock_i[m]=1, go to LOCKED with owner=m and burst_cnt=1.
- LOCKED, lock_i[owner]=1:
  - Only the owner can be granted. Other requesters wait.
  - If req_i[owner]=0, there is no grant and the bus idles (bus_enable_o=0).
  - Each owner grant increments burst_cnt.
- LOCKED, lock_i[owner]=0:
  - Arbitrate as in IDLE in the same cycle.
  - The state goes to IDLE, unless the winner requests lock, in which case the normal IDLE lock rule applies.
- Burst cap: if a locked grant makes burst_cnt reach MAX_BURST, force IDLE and set ptr=(owner+1) mod NUM_M. The owner can re-lock only after winning round-robin again.
- Bus outputs:
  - With a grant, the bus outputs are a mux of the granted master's signals.
  - With no grant, all bus outputs are 0.
- Read return: a granted read (wstrb all zero) sets rvalid_o[m]=1 in the next cycle. Writes produce no rvalid.
- A master may issue back-to-back requests. rvalid_o of access N and the grant of access N+1 may occur in the same cycle.

## Timing
- Grant latency: 0 cycles (combinational from req_i, lock_i, state, ptr). Read data latency: 1 cycle after grant.
- bus_addr_prev_o is updated every cycle with bus_addr_o, including 0 when idle.
- Reset values:
  - gnt_o=0, rvalid_o=0, bus_* outputs=0, bus_addr_prev_o=0
  - state IDLE, ptr=0, owner=0, burst_cnt=0
- Reset mid-burst drops the lock. Reset asserted the cycle after a read grant suppresses that rvalid.
- Simultaneous requests: exactly one grant per cycle; all others stall with gnt_o=0 and must hold their request signals stable.
- burst_cnt is 8 bits and saturates; it never wraps.

## Configuration
- BUS_ARB_LOCK_EN defined: LOCKED state, burst_cnt and MAX_BURST behave as above.
- BUS_ARB_LOCK_EN undefined:
  - lock_i is ignored and the FSM is always IDLE, so arbitration is pure per-access round-robin.
  - The owner and burst_cnt registers are not built. MAX_BURST is unused.

## Test plan
- Reset, then req_i=0b01 with a read of 0x2000_0010 → gnt_o=0b01 in the same cycle, bus_addr_o=0x2000_0010. Next cycle: rvalid_o=0b01, bus_addr_prev_o=0x2000_0010, rdata_o=bus_rvalue_i.
- NUM_M=2, req_i=0b11 held for 4 cycles with lock low → grants 01,10,01,10. Write-only traffic → rvalid_o stays 0.
- Lock defined, MAX_BURST=4, master 1 holds req+lock while master 0 also requests → gnt_o=0b10 for 4 cycles, then 0b01, then 0b10 again on the next cycle.
- Lock defined, master 0 locked with req_i[0]=0 for 2 cycles while master 1 requests → bus_enable_o=0 and gnt_o=0 for both cycles. Master 0 drops lock → master 1 granted that same cycle.
- Assert rst_i during a locked burst, one cycle after a read grant → rvalid_o=0, state IDLE, ptr=0. The next contended request goes to master 0.
- Lock undefined, master 1 asserts lock_i with req_i=0b11 → grants alternate every cycle.
